// File: rtl/dram_req_dispatch.sv
// dram_req_dispatch: front end for the DRAM controller. One L2 request
// stream is queued in an in-order FIFO, the bank field of the head entry is
// decoded, and the request is parked in that bank's slot until the controller
// pulses bank_done. Read completions come back as one-cycle rsp pulses.
// Optional build macro DRAM_REQ_BYPASS_EN: when the FIFO is empty and the
// target slot is free, an accepted request loads its slot directly.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready depends on registered FIFO occupancy only, never on req_valid.
module dram_req_dispatch #(
   parameter int NUMBER_OF_BANKS = 8,
   parameter int NUMBER_OF_ROWS  = 128,
   parameter int NUMBER_OF_COLS  = 8,
   parameter int L2_REQ_WIDTH    = 13,
   parameter int DATA_WIDTH      = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [L2_REQ_WIDTH-1:0]               req_addr,
   input  logic                                  req_rw,
   input  logic [DATA_WIDTH-1:0]                 req_wdata,
   output logic [NUMBER_OF_BANKS-1:0]            slot_valid,
   output logic [NUMBER_OF_BANKS*L2_REQ_WIDTH-1:0] slot_addr,
   output logic [NUMBER_OF_BANKS-1:0]            slot_rw,
   output logic [NUMBER_OF_BANKS*DATA_WIDTH-1:0] slot_wdata,
   input  logic [NUMBER_OF_BANKS-1:0]            bank_done,
   input  logic [NUMBER_OF_BANKS*DATA_WIDTH-1:0] bank_rd_data,
   output logic [NUMBER_OF_BANKS-1:0]            rsp_valid,
   output logic [NUMBER_OF_BANKS*DATA_WIDTH-1:0] rsp_data,
   output logic [$clog2(FIFO_DEPTH):0]           fifo_count
);

   localparam int BANK_W   = $clog2(NUMBER_OF_BANKS);
   localparam int ROW_W    = $clog2(NUMBER_OF_ROWS);
   localparam int COL_W    = $clog2(NUMBER_OF_COLS);
   localparam int BANK_LSB = ROW_W + COL_W;
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int ENT_W    = L2_REQ_WIDTH + 1 + DATA_WIDTH;

   // Entry layout: {addr, rw, wdata}
   logic [ENT_W-1:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [CNT_W-1:0]        count;

   logic [ENT_W-1:0]        head;
   logic [ENT_W-1:0]        req_entry;
   logic [ENT_W-1:0]        load_entry;
   logic [L2_REQ_WIDTH-1:0] head_addr;
   logic [L2_REQ_WIDTH-1:0] load_addr;
   logic [BANK_W-1:0]       head_bank;
   logic [BANK_W-1:0]       load_bank;
   logic                    fifo_empty;
   logic                    push;
   logic                    pop;
   logic                    bypass;
   logic                    fifo_wr;
   logic                    load;

   assign fifo_empty = (count == '0);
   assign req_ready  = (count != CNT_W'(FIFO_DEPTH));
   assign fifo_count = count;
   assign push       = req_valid && req_ready;

   assign head       = fifo_mem[rd_ptr];
   assign head_addr  = head[ENT_W-1 -: L2_REQ_WIDTH];
   assign head_bank  = head_addr[BANK_LSB +: BANK_W];
   // slot_valid is the cycle-start value, so a slot freed this cycle is not
   // reusable until the next edge.
   assign pop        = !fifo_empty && !slot_valid[head_bank];

   assign req_entry  = {req_addr, req_rw, req_wdata};

`ifdef DRAM_REQ_BYPASS_EN
   logic [BANK_W-1:0] in_bank;
   assign in_bank = req_addr[BANK_LSB +: BANK_W];
   // An empty FIFO implies no dispatch this cycle, so bypass never collides
   // with a pop.
   assign bypass  = push && fifo_empty && !slot_valid[in_bank];
`else
   assign bypass  = 1'b0;
`endif

   assign fifo_wr    = push && !bypass;
   assign load       = pop || bypass;
   assign load_entry = bypass ? req_entry : head;
   assign load_addr  = load_entry[ENT_W-1 -: L2_REQ_WIDTH];
   assign load_bank  = load_addr[BANK_LSB +: BANK_W];

   // FIFO storage: data only, no reset needed since count guards reads
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_mem[wr_ptr] <= req_entry;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CNT_W'(fifo_wr) - CNT_W'(pop);
      end
   end

   // Per-bank slots: completion frees a slot (and answers reads), dispatch
   // loads a free one. Both cannot hit one slot in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid <= '0;
         slot_addr  <= '0;
         slot_rw    <= '0;
         slot_wdata <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
      end else begin
         for (int i = 0; i < NUMBER_OF_BANKS; i++) begin
            rsp_valid[i] <= 1'b0;
            if (bank_done[i] && slot_valid[i]) begin
               slot_valid[i] <= 1'b0;
               if (!slot_rw[i]) begin
                  rsp_valid[i]                        <= 1'b1;
                  rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= bank_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            if (load && (load_bank == BANK_W'(i))) begin
               slot_valid[i]                           <= 1'b1;
               slot_addr[i*L2_REQ_WIDTH +: L2_REQ_WIDTH] <= load_addr;
               slot_rw[i]                              <= load_entry[DATA_WIDTH];
               slot_wdata[i*DATA_WIDTH +: DATA_WIDTH]  <= load_entry[DATA_WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: doc/dram_req_dispatch.md
Name: dram_req_dispatch

Overview:
- Upstream feeder for the DRAM controller.
- Accepts one serial L2 request stream (valid/ready), buffers it in an in-order FIFO, decodes the bank field, and loads each request into that bank's request slot.
- The per-bank slots drive the controller's per-bank request inputs.
- Holds each slot until the controller signals completion, then returns read data per bank.

Parameters:
- NUMBER_OF_BANKS, 8: bank slots; power of 2.
- NUMBER_OF_ROWS, 128: rows per bank; power of 2.
- NUMBER_OF_COLS, 8: columns per row; power of 2.
- L2_REQ_WIDTH, 13: address width; must equal log2(BANKS) + log2(ROWS) + log2(COLS).
- DATA_WIDTH, 1: data bits per request.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  L2 request valid.
- req_ready  out  1  FIFO can accept.
- req_addr  in  L2_REQ_WIDTH  bank in [MSBs], then row, then col in [LSBs]; default split is [12:10] / [9:3] / [2:0].
- req_rw  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- slot_valid  out  NUMBER_OF_BANKS  slot i holds a live request.
- slot_addr  out  NUMBER_OF_BANKS*L2_REQ_WIDTH  packed; slot i in bits [i*W +: W].
- slot_rw  out  NUMBER_OF_BANKS  rw per slot.
- slot_wdata  out  NUMBER_OF_BANKS*DATA_WIDTH  packed write data.
- bank_done  in  NUMBER_OF_BANKS  controller completion pulse per bank.
- bank_rd_data  in  NUMBER_OF_BANKS*DATA_WIDTH  read data; valid with bank_done.
- rsp_valid  out  NUMBER_OF_BANKS  one-cycle read-response pulse per bank.
- rsp_data  out  NUMBER_OF_BANKS*DATA_WIDTH  packed read response.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge) clears the FIFO pointers and count, all slot_valid, rsp_valid and rsp_data.
  - slot_addr, slot_rw and slot_wdata reset to 0.
  - req_ready is 1 after reset.
  - Reset mid-operation discards all queued and in-slot requests; no rsp is generated for them.
- req_ready = (fifo_count != FIFO_DEPTH), decoded from registered state only.
  - No combinational path from req_valid or bank_done.
- Push: req_valid && req_ready at an edge writes {addr, rw, wdata} at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Dispatch: each cycle, if the FIFO is non-empty, let b = bank field of the head entry.
  - If slot_valid[b] is 0 at cycle start, the head pops and slot b loads at that edge.
  - Otherwise the head stalls (head-of-line blocking; strict in-order dispatch).
  - At most one dispatch per cycle.
- A slot freed by bank_done in cycle N cannot be reloaded in cycle N. The earliest reload is the edge of cycle N+1.
- Simultaneous push and pop: count is unchanged. Push is allowed when not full even if a pop occurs. No push while full, even with a concurrent pop.
- Latency: a request accepted at edge k is eligible to dispatch at edge k+1. slot_valid rises after edge k+1 if the slot is free.
- Completion: bank_done[i] with slot_valid[i]=1 clears slot_valid[i] at the edge.
  - If slot_rw[i]=0 (read): rsp_valid[i]=1 for exactly the next cycle, and rsp_data slice i = bank_rd_data slice i captured at that edge.
  - rsp_data holds its value until the next read completion on that bank.
  - bank_done[i] while slot_valid[i]=0 is ignored.
  - Multiple banks may complete in the same cycle, independently.
- Write completion produces no rsp.

Optional Feature:
- DRAM_REQ_BYPASS_EN defined: if the FIFO is empty, no dispatch occurs this cycle, and slot_valid[bank(req_addr)]=0, an accepted request loads that slot directly at the accept edge (zero FIFO latency). The FIFO is not written and fifo_count stays 0.
- Not defined: every request passes through the FIFO (1-cycle minimum latency as above).

Test Plan:
- Reset, then push addr=13'h0408 (bank 1, row 1, col 0), rw=0 -> fifo_count=1 after accept; slot_valid=8'h02 one edge later; slot_addr[1]=13'h0408.
- Push bank-3 read, then bank-3 write wdata=1 -> second request stalls with fifo_count=1. Assert bank_done[3] with rd_data=1 -> rsp_valid=8'h08 and rsp_data[3]=1 next cycle; the write loads slot 3 one cycle after done.
- Push 5 requests, all to bank 0, without done -> first dispatches. Remaining 4 fill the FIFO, req_ready=0, fifo_count=4. One bank_done[0] -> req_ready returns to 1 two cycles later.
- Load banks 0, 2, 5 with reads, then pulse bank_done=8'h25 in one cycle -> rsp_valid=8'h25 for exactly 1 cycle; slot_valid=0.
- Fill the FIFO and 3 slots, then assert rst for 1 cycle -> slot_valid=0, fifo_count=0, req_ready=1, rsp_valid=0. No responses follow later bank_done pulses.
- With DRAM_REQ_BYPASS_EN: push to an empty system, bank 7 -> slot_valid[7]=1 immediately after the accept edge, fifo_count stays 0.
